trigger_out_serializer: RTL and testbench

//  Queues trigger event requests and serialises them as 3-bit frames onto a single line for the downstream trigger input decoder.

---
 rtl/trigger_pkg.sv | 20 ++
 rtl/trigger_code_fifo.sv | 45 ++++
 rtl/trigger_out_serializer.sv | 127 ++++++++++++
 tb/tb_trigger_out_serializer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger line: event codes, frame length and the
// serializer FSM state type. The downstream decoder maps codes through the
// same constants, so both ends of the line stay consistent.
package trigger_pkg;

  localparam logic [1:0] TRG_SYN = 2'b00;
  localparam logic [1:0] TRG_RST = 2'b01;
  localparam logic [1:0] TRG_TRG = 2'b10;
  localparam logic [1:0] TRG_RSR = 2'b11;

  localparam int TRG_FRAME_LEN = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B1   = 2'd1,
    ST_B0   = 2'd2,
    ST_GAPW = 2'd3
  } trg_state_t;

endpackage

// File: rtl/trigger_code_fifo.sv
// Synchronous FIFO holding pending 2-bit trigger codes.
// Ports:
//   clk, reset   clock and asynchronous active-high reset (pointers only)
//   push, din    write din when push=1 (caller guarantees !full)
//   pop, dout    dout shows the head entry; pop=1 discards it (caller guarantees !empty)
//   full, empty  occupancy flags derived from the current pointers
module trigger_code_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [1:0] din,
  input  logic       pop,
  output logic [1:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]  mem [DEPTH];
  // One extra pointer bit: equal low bits with differing MSB means full.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/trigger_out_serializer.sv
// Queues trigger event codes and serialises each as a 3-bit frame
// (start '1', code[1], code[0]) onto a single idle-low line. The line only
// moves on clk edges with sync=1, so every bit lasts one sync period.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   sync         bit-period strobe; all line state advances only when high
//   enable       allows new frames to start; a running frame always finishes
//   req_valid/req_code/req_ready   request push interface (ready = FIFO not full)
//   clr_drop     synchronous clear of drop_cnt (wins over an increment)
//   dout         registered serial line
//   busy         frame or gap running, or codes pending
//   frame_done   one-clk pulse alongside code[0] on the line
//   drop_cnt     saturating count of requests refused while full
module trigger_out_serializer
  import trigger_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync,
  input  logic       enable,
  input  logic       req_valid,
  input  logic [1:0] req_code,
  output logic       req_ready,
  input  logic       clr_drop,
  output logic       dout,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] drop_cnt
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  trg_state_t state, state_nxt;
  logic       dout_nxt;
  logic       frame_done_nxt;
  logic [1:0] code_reg, code_nxt;
  logic [3:0] gap_cnt, gap_nxt;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0] fifo_head;

  // Ready comes from pre-clock state: a pop in the same clk frees no room.
  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  trigger_code_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (req_code),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt      = state;
    dout_nxt       = dout;
    code_nxt       = code_reg;
    gap_nxt        = gap_cnt;
    frame_done_nxt = 1'b0;
    fifo_pop       = 1'b0;
    if (sync) begin
      case (state)
        ST_IDLE: begin
          if (enable && !fifo_empty) begin
            fifo_pop  = 1'b1;
            code_nxt  = fifo_head;
            dout_nxt  = 1'b1;
            state_nxt = ST_B1;
          end else begin
            dout_nxt = 1'b0;
          end
        end
        ST_B1: begin
          dout_nxt  = code_reg[1];
          state_nxt = ST_B0;
        end
        ST_B0: begin
          dout_nxt       = code_reg[0];
          frame_done_nxt = 1'b1;
          if (GAP == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            gap_nxt   = 4'(GAP);
            state_nxt = ST_GAPW;
          end
        end
        ST_GAPW: begin
          // gap_cnt counts remaining idle bits including this one.
          dout_nxt = 1'b0;
          gap_nxt  = gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      dout       <= 1'b0;
      frame_done <= 1'b0;
      gap_cnt    <= 4'd0;
      drop_cnt   <= 8'd0;
    end else begin
      state      <= state_nxt;
      dout       <= dout_nxt;
      frame_done <= frame_done_nxt;
      gap_cnt    <= gap_nxt;
      if (clr_drop)                     drop_cnt <= 8'd0;
      else if (req_valid && !req_ready) drop_cnt <= sat_inc8(drop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    code_reg <= code_nxt;
  end

endmodule

// File: tb/tb_trigger_out_serializer.sv
module tb_trigger_out_serializer;
  import trigger_pkg::*;

  logic       clk = 1'b0;
  logic       reset, sync, enable, clr_drop;
  logic       req_valid, req_valid_g;
  logic [1:0] req_code;
  logic       req_ready, dout, busy, frame_done;
  logic [7:0] drop_cnt;
  logic       req_ready_g, dout_g, busy_g, frame_done_g;
  logic [7:0] drop_cnt_g;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  trigger_out_serializer #(.DEPTH(4), .GAP(0)) u_dut (
    .clk(clk), .reset(reset), .sync(sync), .enable(enable),
    .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
    .clr_drop(clr_drop), .dout(dout), .busy(busy),
    .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  trigger_out_serializer #(.DEPTH(4), .GAP(2)) u_dut_gap (
    .clk(clk), .reset(reset), .sync(sync), .enable(enable),
    .req_valid(req_valid_g), .req_code(req_code), .req_ready(req_ready_g),
    .clr_drop(clr_drop), .dout(dout_g), .busy(busy_g),
    .frame_done(frame_done_g), .drop_cnt(drop_cnt_g)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock with the given sync level; returns 1 time unit after the edge.
  task automatic clk1(input logic s);
    sync = s;
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  seq3;
  logic [5:0]  seq6;
  logic [9:0]  seq10;
  logic        any_hi;

  initial begin
    reset = 1'b1; sync = 1'b0; enable = 1'b1; clr_drop = 1'b0;
    req_valid = 1'b0; req_valid_g = 1'b0; req_code = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_fd", frame_done, 0);
    reset = 1'b0;
    clk1(0);

    // 1: TRG with sync every clk
    req_valid = 1'b1; req_code = TRG_TRG;
    clk1(1);
    req_valid = 1'b0;
    chk("t1_push_dout", dout, 0);
    chk("t1_push_busy", busy, 1);
    seq3 = 3'b110;
    for (int i = 0; i < 3; i++) begin
      clk1(1);
      chk($sformatf("t1_bit%0d", i), dout, seq3[2-i]);
      chk($sformatf("t1_fd%0d", i), frame_done, (i == 2));
    end
    chk("t1_busy_end", busy, 0);
    clk1(1);
    chk("t1_idle", dout, 0);

    // 2: RST with one tick every 4 clks
    req_valid = 1'b1; req_code = TRG_RST;
    clk1(0);
    req_valid = 1'b0;
    seq3 = 3'b101;
    for (int b = 0; b < 3; b++) begin
      clk1(1);
      chk($sformatf("t2_bit%0d", b), dout, seq3[2-b]);
      for (int h = 0; h < 3; h++) begin
        clk1(0);
        chk($sformatf("t2_hold%0d_%0d", b, h), dout, seq3[2-b]);
      end
    end
    clk1(1);
    chk("t2_idle", dout, 0);

    // 3: back-to-back SYN then RSR
    req_valid = 1'b1; req_code = TRG_SYN;
    clk1(1);
    req_code = TRG_RSR;
    seq6 = 6'b100111;
    clk1(1);
    req_valid = 1'b0;
    chk("t3_bit0", dout, seq6[5]);
    for (int i = 1; i < 6; i++) begin
      clk1(1);
      chk($sformatf("t3_bit%0d", i), dout, seq6[5-i]);
    end
    clk1(1);
    chk("t3_idle", dout, 0);

    // 4: GAP=2 instance, two queued codes
    req_valid_g = 1'b1; req_code = TRG_TRG;
    clk1(0);
    req_code = TRG_RST;
    clk1(0);
    req_valid_g = 1'b0;
    seq10 = 10'b1100010100;
    for (int i = 0; i < 10; i++) begin
      clk1(1);
      chk($sformatf("t4_bit%0d", i), dout_g, seq10[9-i]);
      if (i == 2) chk("t4_fd", frame_done_g, 1);
    end
    chk("t4_busy_end", busy_g, 0);

    // 5: overflow and drop counter
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_code = 2'(i);
      clk1(0);
      if (i == 2) chk("t5_ready_after3", req_ready, 1);
      if (i == 3) chk("t5_ready_after4", req_ready, 0);
    end
    chk("t5_drop2", drop_cnt, 2);
    for (int i = 0; i < 300; i++) clk1(0);
    chk("t5_drop_sat", drop_cnt, 255);
    clr_drop = 1'b1;
    clk1(0);
    clr_drop = 1'b0;
    req_valid = 1'b0;
    chk("t5_clr_prio", drop_cnt, 0);
    chk("t5_dout_nosync", dout, 0);

    // enable low with codes pending: line idle, busy high
    enable = 1'b0;
    any_hi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clk1(1);
      any_hi = any_hi | dout;
    end
    chk("t6_en0_line", any_hi, 0);
    chk("t6_en0_busy", busy, 1);

    // 6: reset while in B1 (start bit on the line)
    enable = 1'b1;
    clk1(1);
    chk("t6_start", dout, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_ready", req_ready, 1);
    chk("t6_rst_busy", busy, 0);
    clk1(1);
    reset = 1'b0;
    clk1(0);

    // only the post-reset frame reaches the line
    req_valid = 1'b1; req_code = TRG_RSR;
    clk1(0);
    req_valid = 1'b0;
    seq3 = 3'b111;
    for (int i = 0; i < 3; i++) begin
      clk1(1);
      chk($sformatf("t6_lb_bit%0d", i), dout, seq3[2-i]);
    end
    any_hi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clk1(1);
      any_hi = any_hi | dout;
    end
    chk("t6_lb_no_stale", any_hi, 0);
    chk("t6_lb_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
